// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave with a small word register file; register 0 is a constant ID.
// Write and read channels run as independent state machines sharing only the register array.
module axi_lite_reg_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA5A5_0001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int                    IDX_W       = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] WIN_BYTES   = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;

    // Offsets are taken modulo 2^ADDR_WIDTH, so addresses below the base wrap far outside the window.
    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] off);
        return off < WIN_BYTES;
    endfunction

    w_state_t              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [3:0]            w_strb_q, w_strb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s, wr_off_s, rd_off_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [3:0]            wr_strb_s;
    logic [IDX_W-1:0]      wr_idx_s, rd_idx_s;
    logic                  unused_s;

    assign unused_s = ^{awprot, arprot};

    // Ready lines are held low while reset is asserted so nothing handshakes during reset.
    assign awready = rst_n && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_W));
    assign wready  = rst_n && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_AW));
    assign bvalid  = (w_state_q == W_RESP);
    assign bresp   = bresp_q;
    assign aw_hs_s = awvalid && awready;
    assign w_hs_s  = wvalid && wready;

    // The commit uses whichever half arrives this cycle directly and the other from its latch.
    assign wr_addr_s = aw_hs_s ? awaddr : aw_addr_q;
    assign wr_data_s = w_hs_s ? wdata : w_data_q;
    assign wr_strb_s = w_hs_s ? wstrb : w_strb_q;
    assign wr_off_s  = wr_addr_s - BASE_ADDR;
    assign wr_idx_s  = wr_off_s[IDX_W+1:2];

    // Write channel next-state and commit decision.
    always_comb begin
        w_state_d = w_state_q;
        commit_s  = 1'b0;
        aw_addr_d = aw_hs_s ? awaddr : aw_addr_q;
        w_data_d  = w_hs_s ? wdata : w_data_q;
        w_strb_d  = w_hs_s ? wstrb : w_strb_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    commit_s  = 1'b1;
                    w_state_d = W_RESP;
                end else if (aw_hs_s) begin
                    w_state_d = W_HAVE_AW;
                end else if (w_hs_s) begin
                    w_state_d = W_HAVE_W;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_HAVE_AW: begin
                if (w_hs_s) begin
                    commit_s  = 1'b1;
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_HAVE_AW;
                end
            end
            W_HAVE_W: begin
                if (aw_hs_s) begin
                    commit_s  = 1'b1;
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_HAVE_W;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (commit_s) begin
            bresp_d = in_window(wr_off_s) ? RESP_OKAY : RESP_SLVERR;
        end else begin
            bresp_d = bresp_q;
        end
    end

    // Byte-lane register update; index 0 is the ID and never takes writes.
    always_comb begin
        regs_d = regs_q;
        if (commit_s && in_window(wr_off_s) && (wr_idx_s != {IDX_W{1'b0}})) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb_s[i]) begin
                    regs_d[wr_idx_s][8*i +: 8] = wr_data_s[8*i +: 8];
                end else begin
                    regs_d[wr_idx_s][8*i +: 8] = regs_q[wr_idx_s][8*i +: 8];
                end
            end
        end else begin
            regs_d = regs_q;
        end
    end

    // Write channel state, latched halves and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            aw_addr_q <= {ADDR_WIDTH{1'b0}};
            w_data_q  <= {DATA_WIDTH{1'b0}};
            w_strb_q  <= 4'b0000;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bresp_q   <= bresp_d;
        end
    end

    // Register array storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign arready  = !rvalid_q || rready;
    assign ar_hs_s  = arvalid && arready;
    assign rd_off_s = araddr - BASE_ADDR;
    assign rd_idx_s = rd_off_s[IDX_W+1:2];
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;

    // Read channel: load on AR handshake from pre-edge register state, else drain on rready.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            if (!in_window(rd_off_s)) begin
                rdata_d = {DATA_WIDTH{1'b0}};
                rresp_d = RESP_SLVERR;
            end else if (rd_idx_s == {IDX_W{1'b0}}) begin
                rdata_d = ID_VALUE;
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = regs_q[rd_idx_s];
                rresp_d = RESP_OKAY;
            end
        end else if (rready) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // Read channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= {DATA_WIDTH{1'b0}};
            rresp_q  <= 2'b00;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

endmodule
